// File: rtl/adder_share_if.sv
// Request/response bundle for adder_share_arbiter: per-requester operand handshakes
// plus the tagged-sum response channel. The arbiter side uses the slave modport.
interface adder_share_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W:0]           rsp_sum;
    logic [ID_W-1:0]           rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one registered DATA_W-bit adder among NUM_REQ requesters.
// Define ADDER_ARB_ASSERT_EN to compile in simulation-only protocol assertions.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    adder_share_if.slave bus,
    output logic         busy,
    output logic [15:0]  done_cnt
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   rr_ptr_next;
    logic [ID_W-1:0]   grant_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W:0]   sum_reg;
    logic [ID_W-1:0]   id_reg;
    logic [15:0]       done_cnt_reg;

    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] ready_vec;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;
    logic              rsp_fire;

    // Index arithmetic modulo NUM_REQ, valid for any NUM_REQ (not only powers of two).
    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return (v >= NUM_REQ) ? ID_W'(v - NUM_REQ) : ID_W'(v);
    endfunction

    // Walk from the farthest offset down so the nearest valid index after rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap_idx(int'(rr_ptr_reg) + k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(int'(rr_ptr_reg) + k);
            end
        end
    end

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    assign accept   = rst_n && (state_reg == IDLE) && grant_found;
    assign rsp_fire = (state_reg == RESP) && bus.rsp_ready;
    assign rr_ptr_next = wrap_idx(int'(grant_reg) + 1);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign a_arr[gi]     = bus.req_a[gi*DATA_W +: DATA_W];
        assign b_arr[gi]     = bus.req_b[gi*DATA_W +: DATA_W];
        assign ready_vec[gi] = accept && (grant_idx == ID_W'(gi));
    end

    assign bus.req_ready = ready_vec;
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_sum   = sum_reg;
    assign bus.rsp_id    = id_reg;
    assign busy          = (state_reg != IDLE);
    assign done_cnt      = done_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (grant_found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg   <= '0;
            grant_reg    <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            sum_reg      <= '0;
            id_reg       <= '0;
            done_cnt_reg <= '0;
        end else begin
            if (accept) begin
                grant_reg <= grant_idx;
                a_reg     <= a_arr[grant_idx];
                b_reg     <= b_arr[grant_idx];
            end
            if (state_reg == EXEC) begin
                sum_reg <= {1'b0, a_reg} + {1'b0, b_reg};
                id_reg  <= grant_reg;
            end
            if (rsp_fire) begin
                done_cnt_reg <= done_cnt_reg + 16'd1;
                rr_ptr_reg   <= rr_ptr_next;
            end
        end
    end

`ifdef ADDER_ARB_ASSERT_EN
    localparam logic [DATA_W:0] SUM_MAX = {{DATA_W{1'b1}}, 1'b0};

    logic            hold_reg;
    logic [DATA_W:0] sum_prev_reg;
    logic [ID_W-1:0] id_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg     <= 1'b0;
            sum_prev_reg <= '0;
            id_prev_reg  <= '0;
        end else begin
            hold_reg     <= bus.rsp_valid && !bus.rsp_ready;
            sum_prev_reg <= bus.rsp_sum;
            id_prev_reg  <= bus.rsp_id;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(bus.req_ready))
                else $error("req_ready not zero/one-hot: %b", bus.req_ready);
            assert (state_reg == IDLE || bus.req_ready == '0)
                else $error("req_ready high outside IDLE");
            assert (bus.rsp_sum <= SUM_MAX)
                else $error("rsp_sum out of range: %h", bus.rsp_sum);
            assert (int'(bus.rsp_id) < NUM_REQ)
                else $error("rsp_id out of range: %0d", bus.rsp_id);
            if (hold_reg) begin
                assert (bus.rsp_sum == sum_prev_reg && bus.rsp_id == id_prev_reg)
                    else $error("rsp_sum/rsp_id changed under backpressure");
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: vector table, backpressure, reset
// corner cases, then random traffic against a round-robin reference model.
module tb_adder_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [15:0] done_cnt;

    adder_share_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus_if ();

    adder_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn_num = 0;
    int model_ptr = 0;
    int model_done = 0;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] a;
        logic [7:0] b;
        int         id;
        logic [8:0] sum;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: the valid requester at the smallest distance from the pointer.
    function automatic int model_grant(input logic [3:0] m, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [3:0] mask, input logic [31:0] a_pk, input logic [31:0] b_pk,
                           input int exp_id, input logic [8:0] exp_sum, input int stall);
        logic [3:0] exp_ready;
        exp_ready = 4'(1 << exp_id);
        bus_if.req_valid = mask;
        bus_if.req_a     = a_pk;
        bus_if.req_b     = b_pk;
        bus_if.rsp_ready = 1'b1;
        #1;
        check("grant", 32'(bus_if.req_ready), 32'(exp_ready));
        tick();
        // Corrupt operands after acceptance; the latched values must be used.
        bus_if.req_a = ~a_pk;
        bus_if.req_b = ~b_pk;
        #1;
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("exec_ready", 32'(bus_if.req_ready), 32'd0);
        tick();
        bus_if.rsp_ready = (stall == 0);
        #1;
        check("rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        check("rsp_sum", 32'(bus_if.rsp_sum), 32'(exp_sum));
        check("rsp_id", 32'(bus_if.rsp_id), 32'(exp_id));
        for (int s = 0; s < stall; s++) begin
            tick();
            if (s == stall - 1) bus_if.rsp_ready = 1'b1;
            #1;
            check("hold_valid", 32'(bus_if.rsp_valid), 32'd1);
            check("hold_sum", 32'(bus_if.rsp_sum), 32'(exp_sum));
            check("hold_id", 32'(bus_if.rsp_id), 32'(exp_id));
            check("hold_ready", 32'(bus_if.req_ready), 32'd0);
            check("hold_done", 32'(done_cnt), 32'(model_done));
        end
        tick();
        model_done = (model_done + 1) % 65536;
        model_ptr  = (exp_id + 1) % NUM_REQ;
        check("post_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("done_cnt", 32'(done_cnt), 32'(model_done));
        bus_if.req_valid = '0;
        $display("txn %0d: mask=%b id=%0d sum=%h stall=%0d done=%0d",
                 txn_num, mask, bus_if.rsp_id, bus_if.rsp_sum, stall, done_cnt);
        txn_num++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  mask;
        logic [31:0] a_pk;
        logic [31:0] b_pk;
        logic [8:0]  exp_sum;
        int          id;

        tbl[0]  = '{4'b0001, 8'h12, 8'h34, 0, 9'h046};
        tbl[1]  = '{4'b0001, 8'hFF, 8'hFF, 0, 9'h1FE};
        tbl[2]  = '{4'b0100, 8'h80, 8'h80, 2, 9'h100};
        tbl[3]  = '{4'b1111, 8'h01, 8'h02, 3, 9'h003};
        tbl[4]  = '{4'b1111, 8'h7F, 8'h01, 0, 9'h080};
        tbl[5]  = '{4'b1111, 8'h00, 8'h00, 1, 9'h000};
        tbl[6]  = '{4'b1111, 8'hAA, 8'h55, 2, 9'h0FF};
        tbl[7]  = '{4'b1111, 8'hFF, 8'h01, 3, 9'h100};
        tbl[8]  = '{4'b1111, 8'h10, 8'h20, 0, 9'h030};
        tbl[9]  = '{4'b1010, 8'h33, 8'h44, 1, 9'h077};
        tbl[10] = '{4'b0011, 8'hC0, 8'hC0, 0, 9'h180};

        // Reset held with every requester asserting valid.
        rst_n = 1'b0;
        bus_if.req_valid = 4'hF;
        bus_if.req_a     = 32'h0102_0304;
        bus_if.req_b     = 32'h0506_0708;
        bus_if.rsp_ready = 1'b1;
        repeat (3) tick();
        check("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("rst_rsp_sum", 32'(bus_if.rsp_sum), 32'd0);
        check("rst_rsp_id", 32'(bus_if.rsp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        check("first_grant", 32'(bus_if.req_ready), 32'h1);
        bus_if.req_valid = '0;

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].mask, {4{tbl[i].a}}, {4{tbl[i].b}}, tbl[i].id, tbl[i].sum, 0);
        end

        // Backpressure: five stalled cycles in RESP.
        run_txn(4'b0100, {4{8'h0F}}, {4{8'hF0}}, 2, 9'h0FF, 5);

        // No requests: block stays idle with no grant.
        bus_if.rsp_ready = 1'b1;
        repeat (3) begin
            tick();
            check("idle_ready", 32'(bus_if.req_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            mask = 4'($urandom_range(1, 15));
            a_pk = $urandom;
            b_pk = $urandom;
            id   = model_grant(mask, model_ptr);
            exp_sum = {1'b0, a_pk[id*8 +: 8]} + {1'b0, b_pk[id*8 +: 8]};
            run_txn(mask, a_pk, b_pk, id, exp_sum, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                tick();
                check("gap_busy", 32'(busy), 32'd0);
            end
        end

        // Leave the pointer at 3 so a reset-to-zero pointer is observable afterwards.
        run_txn(4'b0100, {4{8'h21}}, {4{8'h43}}, model_grant(4'b0100, model_ptr), 9'h064, 0);

        // Reset while the adder is in EXEC: the transaction disappears.
        bus_if.req_valid = 4'b0100;
        bus_if.req_a     = {4{8'h55}};
        bus_if.req_b     = {4{8'h66}};
        bus_if.rsp_ready = 1'b1;
        tick();
        bus_if.req_valid = '0;
        #1;
        check("midexec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("midrst_done_cnt", 32'(done_cnt), 32'd0);
        check("midrst_rsp_sum", 32'(bus_if.rsp_sum), 32'd0);
        tick();
        tick();
        check("midrst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
        rst_n = 1'b1;
        model_done = 0;
        model_ptr  = 0;
        tick();
        check("postrst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
        run_txn(4'hF, 32'h0403_0201, 32'h1010_1010, 0, 9'h011, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
